mmio_input_ctrl: RTL and testbench
==================================

MMIO_INPUT_CTRL -- requirements
Module: mmio_input_ctrl

Interface
REQ-001 Parameter N_CH, default 4, number of input channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, clk cycles an input must stay stable before it is accepted (>=2).
REQ-003 Parameter BASE_ADDR, default 32'h1001_0100, word-aligned base of the 16-byte register window.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_in  input  N_CH  raw, asynchronous push-button levels, 1 = pressed.
REQ-007 addr  input  32  CPU byte address.
REQ-008 wdata  input  32  CPU write data.
REQ-009 we  input  1  CPU write strobe, one cycle per access.
REQ-010 re  input  1  CPU read strobe, one cycle per access.
REQ-011 rdata  output  32  read data; combinational from addr.
REQ-012 sel  output  1  combinational; 1 when addr[31:4] equals BASE_ADDR[31:4].
REQ-013 irq  output  1  registered interrupt request.

Function
REQ-014 Register map: offset 0x0 STATE (RO, debounced levels); 0x4 EDGE (sticky edge flags, read-to-clear, write-1-to-clear); 0x8 MASK (RW, irq enables); 0xC CTRL (RW, bit0 EDGE_MODE: 0 = capture press, 1 = capture release).
REQ-015 Bits [31:N_CH] of STATE, EDGE and MASK, and bits [31:1] of CTRL, read as 0 and ignore writes.
REQ-016 Each btn_in bit passes through a two-flop synchroniser before any other logic uses it.
REQ-017 Each channel has its own counter, sized for DEBOUNCE_CYCLES-1; it increments while the synchronised input differs from the stable level.
REQ-018 The counter clears in any cycle where the synchronised input equals the stable level, so glitches shorter than DEBOUNCE_CYCLES never propagate.
REQ-019 When the counter reaches DEBOUNCE_CYCLES-1 with the input still different, the stable level takes the input value and the counter clears in the same cycle.
REQ-020 Latency from a clean btn_in change to the STATE bit change is exactly DEBOUNCE_CYCLES+2 cycles.
REQ-021 An EDGE bit sets in the cycle the stable level changes 0->1 (EDGE_MODE=0) or 1->0 (EDGE_MODE=1).
REQ-022 An EDGE bit stays set until cleared by a read or by a write-1.
REQ-023 A read clears all EDGE bits on the clock edge ending the cycle with re=1, sel=1 and offset 0x4; rdata shows the pre-clear value during that cycle.
REQ-024 A write with we=1 to offset 0x4 clears the EDGE bits where wdata is 1.
REQ-025 Simultaneous set and clear of the same EDGE bit leaves the bit at 1 (set wins).
REQ-026 Writes to STATE, and accesses with sel=0, change no register; rdata reads 0 when sel=0.
REQ-027 Changing EDGE_MODE does not alter existing EDGE bits.
REQ-028 irq is registered each cycle as the OR of (EDGE & MASK), so it follows its inputs by one cycle.

Reset
REQ-029 While reset=1 at a clock edge: synchronisers, stable levels, counters, EDGE, MASK, CTRL and irq all go to 0.
REQ-030 Reset asserted during an access or a debounce count aborts it; no EDGE bit is set by the reset itself.
REQ-031 With reset=1, rdata and sel still decode combinationally and show reset register values.

Structure
REQ-032 Register offsets and the EDGE_MODE bit index belong in the shared SoC address package, alongside the other peripheral bases.
REQ-033 One sub-module, debounce_ch (synchroniser, counter and stable level for one channel), is instantiated N_CH times from a generate loop.

Verification
REQ-034 Press ch0 for DEBOUNCE_CYCLES+5 cycles (DEBOUNCE_CYCLES=8) -> STATE=0x1 exactly 10 cycles after the edge, EDGE=0x1; irq stays 0 while MASK=0.
REQ-035 Glitch ch1 high for 7 cycles (DEBOUNCE_CYCLES=8) -> STATE and EDGE remain 0x0.
REQ-036 MASK=0x3, press ch1 -> irq=1 one cycle after EDGE[1] sets; read 0x4 -> rdata=0x2, next cycle EDGE=0, irq=0 one cycle later.
REQ-037 Read of 0x4 in the same cycle EDGE[2] sets -> EDGE[2]=1 afterwards; then write 0x4 with 0x4 -> EDGE=0.
REQ-038 CTRL=1, press then release ch3 -> EDGE[3] sets only on release; reset mid-count -> every register reads 0.

Source files
------------

// File: rtl/mmio_input_ctrl_pkg.sv
// Shared SoC address map: peripheral bases, register offsets and control bit
// positions for the memory-mapped push-button input controller.
package mmio_input_ctrl_pkg;

  localparam logic [31:0] BTN_BASE = 32'h1001_0100;

  // Byte offsets inside the 16-byte register window
  localparam logic [3:0] OFS_STATE = 4'h0;
  localparam logic [3:0] OFS_EDGE  = 4'h4;
  localparam logic [3:0] OFS_MASK  = 4'h8;
  localparam logic [3:0] OFS_CTRL  = 4'hC;

  localparam int EDGE_MODE_BIT = 0;

  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/mmio_input_ctrl_if.sv
// CPU-side register bus for the input controller, with master/slave views.
interface mmio_input_ctrl_if;
  // we/re are single-cycle strobes; the slave is always ready, so there is no
  // ready signal and every strobe completes in the cycle it is presented.
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        sel;
  logic        irq;

  modport master (
    output addr, wdata, we, re,
    input  rdata, sel, irq
  );

  modport slave (
    input  addr, wdata, we, re,
    output rdata, sel, irq
  );
endinterface

// File: rtl/mmio_input_ctrl_debounce_ch.sv
// One button channel: two-flop synchroniser, stability counter and the
// accepted (debounced) level, plus a strobe for the cycle that level flips.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic change_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             differ;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign differ   = sync_q[1] ^ level_q;
    assign change_o = differ && (cnt_q == CNT_MAX);

    // Any cycle back at the stable level restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!differ) begin
            cnt_d = '0;
        end else if (change_o) begin
            cnt_d   = '0;
            level_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/mmio_input_ctrl.sv
// Memory-mapped debounced push-button controller: STATE/EDGE/MASK/CTRL
// registers with sticky edge capture and a registered interrupt.
module mmio_input_ctrl
    import mmio_input_ctrl_pkg::*;
#(
    parameter int          N_CH            = 4,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter logic [31:0] BASE_ADDR       = BTN_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  btn_in,
    mmio_input_ctrl_if.slave bus
);

    logic [N_CH-1:0] level;
    logic [N_CH-1:0] change;
    logic [N_CH-1:0] edge_set;

    logic [N_CH-1:0] edge_q, edge_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic            ctrl_q, ctrl_d;
    logic            irq_q, irq_d;

    logic [3:0]      offset;
    logic            sel;
    logic            rd_edge, wr_edge, wr_mask, wr_ctrl;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .btn_i   (btn_in[g]),
            .level_o (level[g]),
            .change_o(change[g])
        );
    end

    assign sel    = in_window(bus.addr, BASE_ADDR);
    assign offset = bus.addr[3:0];

    assign rd_edge = sel && bus.re && (offset == OFS_EDGE);
    assign wr_edge = sel && bus.we && (offset == OFS_EDGE);
    assign wr_mask = sel && bus.we && (offset == OFS_MASK);
    assign wr_ctrl = sel && bus.we && (offset == OFS_CTRL);

    // level still holds the old value while change is high, so a press is
    // change with level low and a release is change with level high.
    assign edge_set = change & (ctrl_q ? level : ~level);

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q <= '0;
            mask_q <= '0;
            ctrl_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            mask_q <= mask_d;
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        edge_d = edge_q;
        if (rd_edge) begin
            edge_d = '0;
        end
        if (wr_edge) begin
            edge_d = edge_d & ~bus.wdata[N_CH-1:0];
        end
        // New edges are ORed in last so a same-cycle clear cannot lose them.
        edge_d = edge_d | edge_set;
    end

    always_comb begin
        mask_d = mask_q;
        ctrl_d = ctrl_q;
        if (wr_mask) begin
            mask_d = bus.wdata[N_CH-1:0];
        end
        if (wr_ctrl) begin
            ctrl_d = bus.wdata[EDGE_MODE_BIT];
        end
    end

    assign irq_d = |(edge_q & mask_q);

    always_comb begin
        bus.rdata = '0;
        if (sel) begin
            case (offset)
                OFS_STATE: bus.rdata = 32'(level);
                OFS_EDGE:  bus.rdata = 32'(edge_q);
                OFS_MASK:  bus.rdata = 32'(mask_q);
                OFS_CTRL:  bus.rdata = 32'(ctrl_q) << EDGE_MODE_BIT;
                default:   bus.rdata = '0;
            endcase
        end
    end

    assign bus.sel = sel;
    assign bus.irq = irq_q;

endmodule

// File: tb/tb_mmio_input_ctrl.sv
// Directed and randomized bench for mmio_input_ctrl with a windowed reference model.
module tb_mmio_input_ctrl;
  import mmio_input_ctrl_pkg::*;

  localparam int N = 4;
  localparam int DB = 8;
  localparam logic [31:0] BASE = 32'h1001_0100;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] btn;

  mmio_input_ctrl_if bus_if ();

  mmio_input_ctrl #(
    .N_CH(N),
    .DEBOUNCE_CYCLES(DB),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // reference model state
  logic [N-1:0] hist[$];
  logic [N-1:0] m_state, m_edge, m_mask;
  logic m_ctrl, m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Stable level = value the raw input held for the last DB samples, seen
  // through a two-sample synchroniser delay; otherwise it holds.
  task automatic model_step(input logic [N-1:0] b, input logic [31:0] a, input logic [31:0] wd,
                            input logic w, input logic r, input logic rst);
    logic [N-1:0] all1, all0, new_state, rise, fall, set, clr;
    logic s;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < DB + 2; i++) hist.push_back('0);
      m_state = '0; m_edge = '0; m_mask = '0; m_ctrl = 1'b0; m_irq = 1'b0;
      return;
    end
    hist.push_back(b);
    if (hist.size() > DB + 2) void'(hist.pop_front());
    all1 = '1;
    all0 = '1;
    for (int i = 0; i < DB; i++) begin
      all1 = all1 & hist[hist.size() - 3 - i];
      all0 = all0 & ~hist[hist.size() - 3 - i];
    end
    new_state = (m_state | all1) & ~all0;
    rise = new_state & ~m_state;
    fall = ~new_state & m_state;
    set = m_ctrl ? fall : rise;
    s = (a[31:4] == BASE[31:4]);
    clr = '0;
    if (s && r && a[3:0] == 4'h4) clr = '1;
    if (s && w && a[3:0] == 4'h4) clr = clr | wd[N-1:0];
    m_irq = |(m_edge & m_mask);
    m_edge = (m_edge & ~clr) | set;
    if (s && w && a[3:0] == 4'h8) m_mask = wd[N-1:0];
    if (s && w && a[3:0] == 4'hC) m_ctrl = wd[0];
    m_state = new_state;
  endtask

  task automatic tick();
    logic [N-1:0] b;
    logic [31:0] a, wd;
    logic w, r, rst;
    b = btn; a = bus_if.addr; wd = bus_if.wdata; w = bus_if.we; r = bus_if.re; rst = reset;
    @(posedge clk);
    #1;
    model_step(b, a, wd, w, r, rst);
  endtask

  task automatic peek(input logic [3:0] off, input logic [31:0] exp, input string tag);
    bus_if.addr = BASE + 32'(off);
    bus_if.re = 1'b0;
    bus_if.we = 1'b0;
    #1;
    chk(tag, bus_if.rdata, exp);
  endtask

  task automatic check_all(input string tag);
    peek(OFS_STATE, 32'(m_state), {tag, "_state"});
    peek(OFS_EDGE, 32'(m_edge), {tag, "_edge"});
    peek(OFS_MASK, 32'(m_mask), {tag, "_mask"});
    peek(OFS_CTRL, 32'(m_ctrl), {tag, "_ctrl"});
    chk({tag, "_sel"}, 32'(bus_if.sel), 32'd1);
    chk({tag, "_irq"}, 32'(bus_if.irq), 32'(m_irq));
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.addr = a; bus_if.wdata = d; bus_if.we = 1'b1; bus_if.re = 1'b0;
    tick();
    bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus_if.addr = a; bus_if.re = 1'b1; bus_if.we = 1'b0;
    #1;
    chk(tag, bus_if.rdata, exp);
    tick();
    bus_if.re = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    btn = '0;
    bus_if.addr = BASE; bus_if.wdata = '0; bus_if.we = 1'b0; bus_if.re = 1'b0;

    // reset values, including while reset is held
    tick(); tick();
    check_all("in_reset");
    reset = 1'b0;
    tick();
    check_all("post_reset");

    // clean press on ch0: exact latency, edge capture, irq masked
    btn[0] = 1'b1;
    repeat (DB + 1) tick();
    peek(OFS_STATE, 32'h0, "lat_before");
    tick();
    peek(OFS_STATE, 32'h1, "lat_state");
    peek(OFS_EDGE, 32'h1, "lat_edge");
    chk("lat_irq_masked", 32'(bus_if.irq), 32'h0);
    repeat (3) tick();
    btn[0] = 1'b0;
    repeat (DB + 4) tick();
    check_all("ch0_release");
    peek(OFS_EDGE, 32'h1, "edge_sticky");
    bus_write(BASE + 32'h4, 32'h1);
    peek(OFS_EDGE, 32'h0, "w1c_ch0");

    // 7-cycle glitch on ch1 must be rejected
    btn[1] = 1'b1;
    repeat (DB - 1) tick();
    btn[1] = 1'b0;
    for (int i = 0; i < DB + 4; i++) begin
      tick();
      check_all("glitch");
    end
    peek(OFS_STATE, 32'h0, "glitch_state");
    peek(OFS_EDGE, 32'h0, "glitch_edge");

    // masked interrupt and read-to-clear
    bus_write(BASE + 32'h8, 32'h3);
    btn[1] = 1'b1;
    repeat (DB + 2) tick();
    peek(OFS_EDGE, 32'h2, "irq_edge_set");
    chk("irq_lag", 32'(bus_if.irq), 32'h0);
    tick();
    chk("irq_high", 32'(bus_if.irq), 32'h1);
    bus_read(BASE + 32'h4, 32'h2, "rd_edge_pre");
    peek(OFS_EDGE, 32'h0, "rd_edge_cleared");
    chk("irq_hold", 32'(bus_if.irq), 32'h1);
    tick();
    chk("irq_low", 32'(bus_if.irq), 32'h0);
    btn[1] = 1'b0;
    repeat (DB + 4) tick();
    check_all("ch1_release");

    // read-clear colliding with a new edge: set wins
    btn[2] = 1'b1;
    repeat (DB + 1) tick();
    bus_read(BASE + 32'h4, 32'h0, "collide_rdata");
    peek(OFS_EDGE, 32'h4, "collide_set_wins");
    bus_write(BASE + 32'h4, 32'h4);
    peek(OFS_EDGE, 32'h0, "collide_w1c");
    btn[2] = 1'b0;
    repeat (DB + 4) tick();
    check_all("ch2_release");

    // release-capture mode on ch3
    bus_write(BASE + 32'hC, 32'h1);
    peek(OFS_CTRL, 32'h1, "ctrl_mode");
    btn[3] = 1'b1;
    repeat (DB + 4) tick();
    peek(OFS_STATE, 32'h8, "rel_state");
    peek(OFS_EDGE, 32'h0, "rel_no_press_edge");
    btn[3] = 1'b0;
    repeat (DB + 1) tick();
    peek(OFS_EDGE, 32'h0, "rel_before");
    tick();
    peek(OFS_EDGE, 32'h8, "rel_edge");
    bus_write(BASE + 32'hC, 32'h0);
    peek(OFS_EDGE, 32'h8, "mode_change_keeps_edge");
    check_all("mode0");

    // STATE is read-only and out-of-window accesses are ignored
    bus_write(BASE, 32'hF);
    peek(OFS_STATE, 32'h0, "state_ro");
    bus_write(BASE + 32'h18, 32'hF);
    bus_if.addr = BASE + 32'h18;
    #1;
    chk("offwin_sel", 32'(bus_if.sel), 32'h0);
    chk("offwin_rdata", bus_if.rdata, 32'h0);
    check_all("offwin");

    // reset mid-count and mid-access
    btn[1] = 1'b1;
    repeat (5) tick();
    bus_if.addr = BASE + 32'h8; bus_if.wdata = 32'hF; bus_if.we = 1'b1;
    reset = 1'b1;
    tick();
    bus_if.we = 1'b0;
    btn = '0;
    peek(OFS_STATE, 32'h0, "rst_state");
    peek(OFS_EDGE, 32'h0, "rst_edge");
    peek(OFS_MASK, 32'h0, "rst_mask");
    peek(OFS_CTRL, 32'h0, "rst_ctrl");
    chk("rst_irq", 32'(bus_if.irq), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < DB + 4; i++) begin
      tick();
      check_all("after_rst");
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int op;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 11) == 0) btn[c] = ~btn[c];
      op = $urandom_range(0, 63);
      if (op < 8) begin
        bus_read(BASE + 32'h4, 32'(m_edge), "rnd_rdata");
      end else if (op < 12) begin
        bus_write(BASE + 32'h4, $urandom);
      end else if (op < 14) begin
        bus_write(BASE + 32'h8, $urandom);
      end else if (op < 16) begin
        bus_write(BASE + 32'hC, $urandom);
      end else begin
        tick();
      end
      check_all("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
